// File: rtl/cic_pkg.sv
// Width and default constants shared between the CIC integrator and comb
// sections, plus the decimation-counter sizing helper.
package cic_pkg;

    localparam int CIC_IW = 10;
    localparam int CIC_OW = 10;
    localparam int CIC_R  = 4;
    localparam int CIC_N  = 3;
    localparam int CIC_M  = 1;

    // Counter width for a 0..r-1 count; never collapses to zero bits.
    function automatic int cnt_width(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

endpackage

// File: rtl/comb_stage.sv
// One registered CIC differentiator: y = x - x delayed by M valid samples.
// The delay line only shifts on valid inputs, so M counts decimated samples.
module comb_stage
    import cic_pkg::*;
#(
    parameter int W = CIC_IW,
    parameter int M = CIC_M
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_valid,
    input  logic [W-1:0] i_x,
    output logic         o_valid,
    output logic [W-1:0] o_y
);

    // dly[0] holds the most recent accepted input, dly[M-1] the oldest.
    logic [M-1:0][W-1:0] dly;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            dly     <= '0;
            o_valid <= 1'b0;
            o_y     <= '0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                // Modulo-2^W wrap is what makes the integrator overflow cancel.
                o_y    <= i_x - dly[M-1];
                dly[0] <= i_x;
                for (int i = 1; i < M; i++) begin
                    dly[i] <= dly[i-1];
                end
            end
        end
    end

endmodule

// File: rtl/cic_comb_decimator.sv
// CIC decimator back end: keeps every R-th integrator strobe, runs it through
// N registered comb stages and truncates the result to OW bits.
module cic_comb_decimator
    import cic_pkg::*;
#(
    parameter int IW = CIC_IW,
    parameter int OW = CIC_OW,
    parameter int R  = CIC_R,
    parameter int N  = CIC_N,
    parameter int M  = CIC_M
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic [IW-1:0] i_data,
    output logic [OW-1:0] o_data,
    output logic          o_valid
);

    localparam int            CW   = cnt_width(R);
    localparam logic [CW-1:0] LAST = CW'(R - 1);

    logic [CW-1:0] dec_cnt;
    logic          accept;
    logic          acc_valid;
    logic [IW-1:0] acc_data;

    // Index 0 is the accepted sample, index k the output of comb stage k.
    wire [N:0]         vld_pipe;
    wire [N:0][IW-1:0] stage_x;

    assign accept = i_ce && (dec_cnt == LAST);

    // Counter advances on strobes only, so gaps in i_ce stall decimation.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            dec_cnt   <= '0;
            acc_valid <= 1'b0;
            acc_data  <= '0;
        end else begin
            acc_valid <= accept;
            if (accept) begin
                acc_data <= i_data;
            end
            if (i_ce) begin
                dec_cnt <= (dec_cnt == LAST) ? '0 : dec_cnt + 1'b1;
            end
        end
    end

    assign vld_pipe[0] = acc_valid;
    assign stage_x[0]  = acc_data;

    generate
        for (genvar k = 0; k < N; k++) begin : g_stage
            comb_stage #(
                .W (IW),
                .M (M)
            ) u_stage (
                .i_clk   (i_clk),
                .i_reset (i_reset),
                .i_valid (vld_pipe[k]),
                .i_x     (stage_x[k]),
                .o_valid (vld_pipe[k+1]),
                .o_y     (stage_x[k+1])
            );
        end
    endgenerate

    // Output register holds between pulses; only the top OW bits survive.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= vld_pipe[N];
            if (vld_pipe[N]) begin
                o_data <= stage_x[N][IW-1 -: OW];
            end
        end
    end

endmodule

// File: tb/tb_cic_comb_decimator.sv
// Directed bench for cic_comb_decimator: an N=3 and an N=1 instance share the
// same stimulus; each step is checked against hand-computed values.
module tb_cic_comb_decimator;

    logic       clk;
    logic       i_reset;
    logic       i_ce;
    logic [9:0] i_data;
    logic [9:0] o3_data, o1_data;
    logic       o3_valid, o1_valid;

    int checks = 0;
    int errors = 0;

    // Expected N=3 ramp outputs: 3, -2, -1, 0, 0, 0
    logic [9:0] exp3 [6];
    // Expected N=1 wrap outputs: -324, 400, 400, 400
    logic [9:0] expw [4];

    cic_comb_decimator #(.IW(10), .OW(10), .R(4), .N(3), .M(1)) dut3 (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_ce    (i_ce),
        .i_data  (i_data),
        .o_data  (o3_data),
        .o_valid (o3_valid)
    );

    cic_comb_decimator #(.IW(10), .OW(10), .R(4), .N(1), .M(1)) dut1 (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_ce    (i_ce),
        .i_data  (i_data),
        .o_data  (o1_data),
        .o_valid (o1_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Called at a falling edge: drive inputs, let one rising edge consume them,
    // return at the next falling edge with outputs settled.
    task automatic cyc(input logic ce, input logic [9:0] d);
        i_ce   = ce;
        i_data = d;
        @(negedge clk);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_ce    = 1'b0;
        i_data  = '0;
        @(negedge clk);
        @(negedge clk);
        i_reset = 1'b0;
    endtask

    // Ramp 0,1,2,... on every g-th cycle (999 on idle cycles), checked on dut3.
    task automatic ramp(input string tag, input int g);
        logic [9:0] last;
        logic       exp_v;
        int         k;
        last = '0;
        for (int c = 0; c <= g * 23 + 4; c++) begin
            cyc((c % g) == 0, ((c % g) == 0) ? 10'(c / g) : 10'd999);
            exp_v = 1'b0;
            if (c >= 4 && ((c - 4) % g) == 0) begin
                k = (c - 4) / g;
                if (k >= 3 && ((k - 3) % 4) == 0) begin
                    exp_v = 1'b1;
                    last  = exp3[(k - 3) / 4];
                end
            end
            chk({tag, "_valid"}, {9'b0, o3_valid}, {9'b0, exp_v});
            chk({tag, "_data"}, o3_data, last);
        end
    endtask

    initial begin
        exp3[0] = 10'd3;      exp3[1] = 10'(-2);  exp3[2] = 10'(-1);
        exp3[3] = 10'd0;      exp3[4] = 10'd0;    exp3[5] = 10'd0;
        expw[0] = 10'(-324);  expw[1] = 10'd400;  expw[2] = 10'd400;  expw[3] = 10'd400;

        i_reset = 1'b1;
        i_ce    = 1'b0;
        i_data  = '0;
        @(negedge clk);

        // Reset state
        chk("rst_valid3", {9'b0, o3_valid}, 10'd0);
        chk("rst_data3", o3_data, 10'd0);
        chk("rst_valid1", {9'b0, o1_valid}, 10'd0);
        chk("rst_data1", o1_data, 10'd0);
        do_reset();

        // Ramp with a strobe every cycle
        ramp("ramp", 1);

        // Latency: one accepted sample (value 5) at edge 3 -> o_valid after edge 7 only
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            cyc(c < 4, (c < 4) ? 10'd5 : 10'd999);
            chk("lat_valid", {9'b0, o3_valid}, {9'b0, (c == 7)});
            chk("lat_data", o3_data, (c >= 7) ? 10'd5 : 10'd0);
        end

        // Asynchronous reset clears outputs before any clock edge
        chk("pre_arst_data1", o1_data, 10'd5);
        #2;
        i_reset = 1'b1;
        #1;
        chk("arst_data3", o3_data, 10'd0);
        chk("arst_valid3", {9'b0, o3_valid}, 10'd0);
        chk("arst_data1", o1_data, 10'd0);
        @(negedge clk);
        i_reset = 1'b0;

        // Wrap on N=1: 400+100k modulo 2^10, accepted at edges 3,7,11,15
        do_reset();
        begin
            logic [9:0] last;
            logic       exp_v;
            last = '0;
            for (int c = 0; c <= 17; c++) begin
                cyc(1'b1, 10'(400 + 100 * c));
                exp_v = (c >= 5) && (((c - 5) % 4) == 0);
                if (exp_v) last = expw[(c - 5) / 4];
                chk("wrap_valid", {9'b0, o1_valid}, {9'b0, exp_v});
                chk("wrap_data", o1_data, last);
            end
        end

        // Gapped strobes: every 3rd cycle, same output sequence 12 cycles apart
        do_reset();
        ramp("gap", 3);

        // Reset one cycle after an accepted sample discards it
        do_reset();
        for (int c = 0; c <= 3; c++) cyc(1'b1, 10'(c));
        i_reset = 1'b1;
        i_ce    = 1'b0;
        @(negedge clk);
        chk("midrst_valid", {9'b0, o3_valid}, 10'd0);
        i_reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cyc(1'b0, 10'd999);
            chk("flush_valid", {9'b0, o3_valid}, 10'd0);
            chk("flush_data", o3_data, 10'd0);
        end
        ramp("rerun", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
